// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared CPU constants and the IF/ID queue entry type
//
// Purpose : constants shared by the IF stage and the IF/ID queue.
//           CPU_NOP_INSTR   - instruction word shown to ID when nothing is queued
//           CPU_INT_VECTOR  - interrupt handler entry address (used by IF)
//           entry_t         - one queued {pc, instr} pair
package if_id_queue_pkg;

  localparam logic [31:0] CPU_NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] CPU_INT_VECTOR = 32'h0000_1000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Sequential successor of an instruction address.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - IF/ID queue handshake bundle
//
// Purpose : groups the IF push side, the ID pop side and the redirect controls.
// Ports   : if_valid/if_pc/if_instr/if_ready - push handshake from IF
//           id_valid/id_pc/id_instr/id_ready - pop handshake toward ID
//           flush/int_detected               - redirect controls
//           epc                              - captured interrupt return PC
// Modports: master - the pipeline side driving IF/ID controls
//           slave  - the queue itself
interface if_id_if;
  import if_id_queue_pkg::*;

  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready;
  logic        flush;
  logic        int_detected;
  logic [31:0] epc;

  modport master (
    output if_valid, if_pc, if_instr, id_ready, flush, int_detected,
    input  if_ready, id_valid, id_pc, id_instr, epc
  );

  modport slave (
    input  if_valid, if_pc, if_instr, id_ready, flush, int_detected,
    output if_ready, id_valid, id_pc, id_instr, epc
  );

endinterface

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - circular IF/ID instruction queue with flush and EPC capture
//
// Purpose : DEPTH-entry FIFO between fetch and decode. Head entry is shown to ID
//           combinationally; empty queue shows {0, NOP_INSTR}. flush or
//           int_detected empties the queue at the next edge; int_detected also
//           captures the interrupt return PC into epc.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-low reset
//           bus   - if_id_if.slave handshake bundle
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset,
  if_id_if.slave bus
);

  localparam int          PW         = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   last_pop_pc_q, last_pop_pc_d;
  logic [31:0]   epc_q, epc_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  logic if_ready, id_valid, push, pop, clear;

  // Handshake outputs depend on registered count only, so a pop cannot
  // make room for a push in the same cycle.
  assign if_ready     = (count_q != FULL_COUNT);
  assign id_valid     = (count_q != '0);
  assign bus.if_ready = if_ready;
  assign bus.id_valid = id_valid;
  assign bus.id_pc    = id_valid ? mem_q[head_q].pc    : 32'h0;
  assign bus.id_instr = id_valid ? mem_q[head_q].instr : NOP_INSTR;
  assign bus.epc      = epc_q;

  assign push  = bus.if_valid && if_ready;
  assign pop   = id_valid && bus.id_ready;
  assign clear = bus.flush || bus.int_detected;

  always_comb begin
    mem_d         = mem_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    last_pop_pc_d = last_pop_pc_q;
    epc_d         = epc_q;

    if (clear) begin
      // Redirect wins over any push/pop in the same cycle.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = '{pc: bus.if_pc, instr: bus.if_instr};
        tail_d        = tail_q + 1'b1;  // power-of-two depth wraps naturally
      end
      if (pop) begin
        head_d        = head_q + 1'b1;
        last_pop_pc_d = bus.id_pc;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // Return to the oldest instruction not yet handed to ID.
    if (bus.int_detected) begin
      if (id_valid)          epc_d = bus.id_pc;
      else if (bus.if_valid) epc_d = bus.if_pc;
      else                   epc_d = next_seq_pc(last_pop_pc_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      last_pop_pc_q <= 32'h0;
      epc_q         <= 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: 32'h0, instr: NOP_INSTR};
      end
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      last_pop_pc_q <= last_pop_pc_d;
      epc_q         <= epc_d;
      mem_q         <= mem_d;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - directed self-checking bench for if_id_queue
module tb_if_id_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  if_id_if bus ();

  if_id_queue #(
    .DEPTH    (2),
    .NOP_INSTR(NOP)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl, input logic intr);
    bus.if_valid     = v;
    bus.if_pc        = pc;
    bus.if_instr     = ins;
    bus.id_ready     = rdy;
    bus.flush        = fl;
    bus.int_detected = intr;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_if_ready", bus.if_ready, 32'h1);
    chk("rst_id_valid", bus.id_valid, 32'h0);
    chk("rst_id_pc",    bus.id_pc,    32'h0);
    chk("rst_id_instr", bus.id_instr, NOP);
    chk("rst_epc",      bus.epc,      32'h0);
    step();
    rst_n = 1'b1;

    // First push: no same-cycle bypass, visible next cycle.
    drive(1'b1, 32'h0, 32'h2008_0001, 1'b0, 1'b0, 1'b0);
    #1;
    chk("push0_no_bypass", bus.id_valid, 32'h0);
    step();
    chk("push0_id_valid", bus.id_valid, 32'h1);
    chk("push0_id_pc",    bus.id_pc,    32'h0);
    chk("push0_id_instr", bus.id_instr, 32'h2008_0001);
    chk("push0_if_ready", bus.if_ready, 32'h1);

    // Fill, then hold if_valid while full.
    drive(1'b1, 32'h4, 32'h2009_0002, 1'b0, 1'b0, 1'b0);
    step();
    chk("full_if_ready", bus.if_ready, 32'h0);
    drive(1'b1, 32'h8, 32'hDEAD_0008, 1'b0, 1'b0, 1'b0);
    step();
    chk("full_hold_if_ready", bus.if_ready, 32'h0);
    chk("full_hold_id_pc",    bus.id_pc,    32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    chk("pop1_id_pc",    bus.id_pc,    32'h4);
    chk("pop1_id_instr", bus.id_instr, 32'h2009_0002);
    chk("pop1_if_ready", bus.if_ready, 32'h1);

    // Full with simultaneous push and pop: push rejected, count drops to 1.
    drive(1'b1, 32'h8, 32'hA000_0008, 1'b0, 1'b0, 1'b0);
    step();
    chk("refill_if_ready", bus.if_ready, 32'h0);
    drive(1'b1, 32'hC, 32'hA000_000C, 1'b1, 1'b0, 1'b0);
    step();
    chk("pp_if_ready", bus.if_ready, 32'h1);
    chk("pp_id_valid", bus.id_valid, 32'h1);
    chk("pp_id_pc",    bus.id_pc,    32'h8);

    // Entries {0x8,0xC}, then push 0x10 together with flush.
    drive(1'b1, 32'hC, 32'hA000_000C, 1'b0, 1'b0, 1'b0);
    step();
    chk("q8c_if_ready", bus.if_ready, 32'h0);
    drive(1'b1, 32'h10, 32'hA000_0010, 1'b0, 1'b1, 1'b0);
    step();
    chk("flush_id_valid", bus.id_valid, 32'h0);
    chk("flush_id_instr", bus.id_instr, NOP);
    chk("flush_if_ready", bus.if_ready, 32'h1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    chk("flush_stays_empty", bus.id_valid, 32'h0);

    // Pop 0x14, then interrupt with nothing valid -> last_pop_pc + 4.
    drive(1'b1, 32'h14, 32'hA000_0014, 1'b0, 1'b0, 1'b0);
    step();
    chk("p14_id_pc", bus.id_pc, 32'h14);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    chk("p14_popped_empty", bus.id_valid, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    chk("int_seq_epc", bus.epc, 32'h18);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("epc_hold", bus.epc, 32'h18);

    // Head 0x20 valid: id_pc wins over if_pc, and over a concurrent flush.
    drive(1'b1, 32'h20, 32'hA000_0020, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h24, 32'hA000_0024, 1'b0, 1'b1, 1'b1);
    step();
    chk("int_head_epc",   bus.epc,      32'h20);
    chk("int_head_empty", bus.id_valid, 32'h0);

    // Empty queue, IF presenting 0x30 -> epc=if_pc, push discarded.
    drive(1'b1, 32'h30, 32'hA000_0030, 1'b0, 1'b0, 1'b1);
    step();
    chk("int_if_epc",   bus.epc,      32'h30);
    chk("int_if_empty", bus.id_valid, 32'h0);

    // Mid-cycle reset while full.
    drive(1'b1, 32'h40, 32'hA000_0040, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h44, 32'hA000_0044, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_full", bus.if_ready, 32'h0);
    chk("pre_rst_valid", bus.id_valid, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_id_valid", bus.id_valid, 32'h0);
    chk("async_rst_id_instr", bus.id_instr, NOP);
    #4;
    rst_n = 1'b1;
    #1;
    chk("rel_if_ready", bus.if_ready, 32'h1);
    chk("rel_epc",      bus.epc,      32'h0);
    chk("rel_id_valid", bus.id_valid, 32'h0);
    step();
    chk("rel_after_edge_id_valid", bus.id_valid, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 2, number of queue entries; SHALL be a power of two and at least 2.
REQ-002 Parameter NOP_INSTR, default 32'h00000000, instruction word presented to ID when the queue is empty.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 if_valid  input  1  IF presents a fetched instruction this cycle.
REQ-006 if_pc  input  32  PC of the presented instruction.
REQ-007 if_instr  input  32  presented instruction word.
REQ-008 if_ready  output  1  queue accepts a push this cycle; drives IF PCWrite.
REQ-009 id_valid  output  1  head entry is valid for ID.
REQ-010 id_pc  output  32  PC of the head entry.
REQ-011 id_instr  output  32  instruction of the head entry.
REQ-012 id_ready  input  1  ID consumes the head entry this cycle.
REQ-013 flush  input  1  branch/jump redirect; discards all entries.
REQ-014 int_detected  input  1  interrupt taken; discards all entries and captures the EPC.
REQ-015 epc  output  32  registered return PC for the interrupt handler.

Function
REQ-016 Push: if_valid && if_ready SHALL write {if_pc, if_instr} at the tail, then advance the tail with wrap-around modulo DEPTH.
REQ-017 Pop: id_valid && id_ready SHALL advance the head with wrap-around modulo DEPTH.
REQ-018 count SHALL track occupancy 0..DEPTH: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-019 if_ready SHALL be (count != DEPTH), combinational from registered count only; there is no push-through when full, even if a pop occurs.
REQ-020 id_valid SHALL be (count != 0); id_pc/id_instr SHALL come combinationally from the head entry when valid, and be 32'h0 / NOP_INSTR when empty.
REQ-021 Latency: a push in cycle N SHALL be visible at id_* in cycle N+1; there is no same-cycle bypass when empty.
REQ-022 flush or int_detected SHALL set count, head and tail to 0 at the next edge; a push or pop in the same cycle SHALL be discarded.
REQ-023 On int_detected, epc SHALL load id_pc if id_valid, else if_pc if if_valid, else last_pop_pc + 4.
REQ-024 last_pop_pc SHALL be an internal register loaded with id_pc on every pop.
REQ-025 If int_detected and flush are both asserted, int_detected SHALL govern epc; the flush behaviour is identical.
REQ-026 epc SHALL hold its value at all other times.
REQ-027 Pushing when full and popping when empty are impossible by construction, because the handshakes gate them; storage SHALL NOT change in those cases.

Reset
REQ-028 While reset is low: count, head, tail, last_pop_pc and epc SHALL be 0, and all entries SHALL be {32'h0, NOP_INSTR}.
REQ-029 Outputs during reset: if_ready=1, id_valid=0, id_pc=0, id_instr=NOP_INSTR, epc=0.
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Structure
REQ-031 NOP_INSTR default and the interrupt vector constant 32'h00001000 SHALL live in the shared CPU package; the IF stage and this block SHALL both import them.
REQ-032 Storage and pointers SHALL be inline; no sub-module is required.

Verification
REQ-033 Reset release, then push pc=0x0/instr=0x20080001 with id_ready=0 -> next cycle id_valid=1, id_pc=0x0, if_ready=1.
REQ-034 Push 0x0, then push 0x4 with id_ready=0 -> count=2, if_ready=0; if_valid held -> no third write; one pop -> id_pc=0x4 and if_ready=1 next cycle.
REQ-035 Full queue with push and pop in the same cycle -> the push is rejected because if_ready=0, and count becomes 1.
REQ-036 Entries {0x8,0xC} plus a push of 0x10 with flush=1 -> next cycle id_valid=0, id_instr=NOP_INSTR, and 0x10 is never popped.
REQ-037 Pop 0x14, queue empty, if_valid=0, int_detected=1 -> epc=0x18; repeat with head 0x20 valid -> epc=0x20.
REQ-038 reset low for half a cycle while count=2 -> id_valid=0 immediately; at reset release if_ready=1 and epc=0.
